// File: rtl/voting_pkg.sv
// Shared types and helpers for the ballot sequencer: phase encoding,
// candidate index width and a saturating counter increment.
package voting_pkg;

  localparam int N_CAND_DEF = 4;
  localparam int CAND_W     = $clog2(N_CAND_DEF);

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_OPEN    = 3'd1,
    PH_ARMED   = 3'd2,
    PH_CAST    = 3'd3,
    PH_CLOSED  = 3'd4,
    PH_RESULTS = 3'd5
  } phase_t;

  // Increment v unless it already holds the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/ballot_timer.sv
// Loadable down-counter: load wins over count; expire is high while enabled at zero.
// Shared by the armed-ballot timeout, the cast lockout hold and the results scan.
module ballot_timer #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/ballot_controller.sv
// Poll session / ballot sequencer for the voting machine: arms one ballot per officer
// pulse, grants single-button votes one cycle later, locks out during CAST, scans results.
module ballot_controller
  import voting_pkg::*;
#(
  parameter int N_CAND      = N_CAND_DEF,
  parameter int HOLD_CYCLES = 10,
  parameter int ARM_TIMEOUT = 1000,
  parameter int SCAN_CYCLES = 50,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              open_poll,
  input  logic              close_poll,
  input  logic              officer_enable,
  input  logic [N_CAND-1:0] vote_req,
  output logic [N_CAND-1:0] vote_grant,
  output logic              logger_en,
  output logic [2:0]        phase,
  output logic              armed_led,
  output logic              cast_led,
  output logic [CNT_W-1:0]  ballot_cnt,
  output logic [CNT_W-1:0]  spoiled_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [CAND_W-1:0] disp_sel,
  output logic              disp_valid
);

  localparam int TMR_MAX = (ARM_TIMEOUT > HOLD_CYCLES)
                         ? ((ARM_TIMEOUT > SCAN_CYCLES) ? ARM_TIMEOUT : SCAN_CYCLES)
                         : ((HOLD_CYCLES > SCAN_CYCLES) ? HOLD_CYCLES : SCAN_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  phase_t              state_q, state_d;
  logic [N_CAND-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]    ballot_q, ballot_d;
  logic [CNT_W-1:0]    spoiled_q, spoiled_d;
  logic [CNT_W-1:0]    timeout_q, timeout_d;
  logic [CAND_W-1:0]   disp_sel_q, disp_sel_d;
  logic                close_pend_q, close_pend_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_en;
  logic                tmr_expire;
  logic                req_one;
  logic                req_multi;

  // A request is unambiguous only when exactly one bit is set.
  assign req_one   = (vote_req != '0) && ((vote_req & (vote_req - N_CAND'(1))) == '0);
  assign req_multi = (vote_req != '0) && !req_one;

  ballot_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    ballot_d     = ballot_q;
    spoiled_d    = spoiled_q;
    timeout_d    = timeout_q;
    disp_sel_d   = disp_sel_q;
    close_pend_d = close_pend_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;

    case (state_q)
      PH_IDLE: begin
        if (open_poll) begin
          state_d = PH_OPEN;
        end
      end

      PH_OPEN: begin
        if (close_poll) begin
          state_d = PH_CLOSED;
        end else if (officer_enable) begin
          state_d  = PH_ARMED;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ARM_TIMEOUT - 1);
        end
      end

      PH_ARMED: begin
        tmr_en = 1'b1;
        // A vote in the same cycle as close is still processed; the close waits for CAST expiry.
        if (req_one || req_multi) begin
          state_d      = PH_CAST;
          tmr_load     = 1'b1;
          tmr_val      = TMR_W'(HOLD_CYCLES - 1);
          close_pend_d = close_poll;
          if (req_one) begin
            grant_d  = vote_req;
            ballot_d = CNT_W'(sat_inc(32'(ballot_q), CNT_W));
          end else begin
            spoiled_d = CNT_W'(sat_inc(32'(spoiled_q), CNT_W));
          end
        end else if (close_poll) begin
          state_d = PH_CLOSED;
        end else if (tmr_expire) begin
          state_d   = PH_OPEN;
          timeout_d = CNT_W'(sat_inc(32'(timeout_q), CNT_W));
        end
      end

      PH_CAST: begin
        tmr_en = 1'b1;
        if (close_poll) begin
          close_pend_d = 1'b1;
        end
        if (tmr_expire) begin
          state_d      = (close_pend_q || close_poll) ? PH_CLOSED : PH_OPEN;
          close_pend_d = 1'b0;
        end
      end

      PH_CLOSED: begin
        if (officer_enable) begin
          state_d    = PH_RESULTS;
          disp_sel_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(SCAN_CYCLES - 1);
        end
      end

      PH_RESULTS: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          disp_sel_d = (disp_sel_q == CAND_W'(N_CAND - 1)) ? '0 : (disp_sel_q + CAND_W'(1));
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(SCAN_CYCLES - 1);
        end
      end

      default: begin
        state_d = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= PH_IDLE;
      grant_q      <= '0;
      ballot_q     <= '0;
      spoiled_q    <= '0;
      timeout_q    <= '0;
      disp_sel_q   <= '0;
      close_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ballot_q     <= ballot_d;
      spoiled_q    <= spoiled_d;
      timeout_q    <= timeout_d;
      disp_sel_q   <= disp_sel_d;
      close_pend_q <= close_pend_d;
    end
  end

  assign vote_grant  = grant_q;
  assign phase       = state_q;
  assign logger_en   = (state_q == PH_OPEN) || (state_q == PH_ARMED) || (state_q == PH_CAST);
  assign armed_led   = (state_q == PH_ARMED);
  assign cast_led    = (state_q == PH_CAST);
  assign disp_valid  = (state_q == PH_RESULTS);
  assign disp_sel    = disp_sel_q;
  assign ballot_cnt  = ballot_q;
  assign spoiled_cnt = spoiled_q;
  assign timeout_cnt = timeout_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: a default-parameter instance for session flow
// and a narrow-counter, short-hold instance for saturation.
module tb_ballot_controller;

  logic        clock;
  logic        reset;
  logic        open_poll, close_poll, officer_enable;
  logic [3:0]  vote_req;
  logic [3:0]  vote_grant;
  logic        logger_en, armed_led, cast_led, disp_valid;
  logic [2:0]  phase;
  logic [15:0] ballot_cnt, spoiled_cnt, timeout_cnt;
  logic [1:0]  disp_sel;

  logic        s_open_poll, s_close_poll, s_officer_enable;
  logic [3:0]  s_vote_req;
  logic [3:0]  s_vote_grant;
  logic        s_logger_en, s_armed_led, s_cast_led, s_disp_valid;
  logic [2:0]  s_phase;
  logic [3:0]  s_ballot_cnt, s_spoiled_cnt, s_timeout_cnt;
  logic [1:0]  s_disp_sel;

  int vecs = 0;
  int errs = 0;

  ballot_controller u_dut (
    .clock          (clock),
    .reset          (reset),
    .open_poll      (open_poll),
    .close_poll     (close_poll),
    .officer_enable (officer_enable),
    .vote_req       (vote_req),
    .vote_grant     (vote_grant),
    .logger_en      (logger_en),
    .phase          (phase),
    .armed_led      (armed_led),
    .cast_led       (cast_led),
    .ballot_cnt     (ballot_cnt),
    .spoiled_cnt    (spoiled_cnt),
    .timeout_cnt    (timeout_cnt),
    .disp_sel       (disp_sel),
    .disp_valid     (disp_valid)
  );

  ballot_controller #(
    .N_CAND(4), .HOLD_CYCLES(2), .ARM_TIMEOUT(8), .SCAN_CYCLES(4), .CNT_W(4)
  ) u_sat (
    .clock          (clock),
    .reset          (reset),
    .open_poll      (s_open_poll),
    .close_poll     (s_close_poll),
    .officer_enable (s_officer_enable),
    .vote_req       (s_vote_req),
    .vote_grant     (s_vote_grant),
    .logger_en      (s_logger_en),
    .phase          (s_phase),
    .armed_led      (s_armed_led),
    .cast_led       (s_cast_led),
    .ballot_cnt     (s_ballot_cnt),
    .spoiled_cnt    (s_spoiled_cnt),
    .timeout_cnt    (s_timeout_cnt),
    .disp_sel       (s_disp_sel),
    .disp_valid     (s_disp_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic arm();
    officer_enable = 1'b1; tick(); officer_enable = 1'b0;
  endtask

  task automatic vote(input logic [3:0] v);
    vote_req = v; tick(); vote_req = '0;
  endtask

  // Counts CAST cycles starting from the current one; stray grants after the first cycle are tallied.
  task automatic wait_cast(output int n, output int extra);
    n = 0;
    extra = 0;
    while (cast_led === 1'b1 && n < 40) begin
      if (n > 0 && vote_grant !== 4'b0000) extra++;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    open_poll = 0; close_poll = 0; officer_enable = 0; vote_req = '0;
    s_open_poll = 0; s_close_poll = 0; s_officer_enable = 0; s_vote_req = '0;
    repeat (3) tick();
    reset = 1'b0;
    vecs++; if (phase !== 3'd0) begin errs++; $display("FAIL reset_phase: got %0d want 0", phase); end
    vecs++; if (vote_grant !== 4'b0000) begin errs++; $display("FAIL reset_grant: got %b want 0000", vote_grant); end
    vecs++; if ({logger_en, armed_led, cast_led, disp_valid} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags: got %b want 0000", {logger_en, armed_led, cast_led, disp_valid}); end
    vecs++; if ({ballot_cnt, spoiled_cnt, timeout_cnt} !== 48'd0) begin
      errs++; $display("FAIL reset_counts: got %h want 0", {ballot_cnt, spoiled_cnt, timeout_cnt}); end
    vecs++; if (disp_sel !== 2'd0) begin errs++; $display("FAIL reset_disp_sel: got %0d want 0", disp_sel); end
  endtask

  task automatic test_vote();
    int n, extra;
    open_poll = 1'b1; tick(); open_poll = 1'b0;
    vecs++; if (phase !== 3'd1 || logger_en !== 1'b1) begin
      errs++; $display("FAIL open: phase %0d logger_en %b want 1/1", phase, logger_en); end
    arm();
    vecs++; if (phase !== 3'd2 || armed_led !== 1'b1) begin
      errs++; $display("FAIL arm: phase %0d armed_led %b want 2/1", phase, armed_led); end
    vote(4'b0100);
    vecs++; if (vote_grant !== 4'b0100) begin errs++; $display("FAIL grant: got %b want 0100", vote_grant); end
    vecs++; if (ballot_cnt !== 16'd1) begin errs++; $display("FAIL ballot_cnt: got %0d want 1", ballot_cnt); end
    vecs++; if (logger_en !== 1'b1) begin errs++; $display("FAIL cast_logger_en: got %b want 1", logger_en); end
    wait_cast(n, extra);
    vecs++; if (n !== 10) begin errs++; $display("FAIL cast_len: got %0d want 10", n); end
    vecs++; if (extra !== 0) begin errs++; $display("FAIL grant_width: got %0d extra cycles want 0", extra); end
    vecs++; if (phase !== 3'd1) begin errs++; $display("FAIL after_cast_phase: got %0d want 1", phase); end
  endtask

  task automatic test_spoiled();
    int n, extra;
    arm();
    vote(4'b0011);
    vecs++; if (vote_grant !== 4'b0000) begin errs++; $display("FAIL spoil_grant: got %b want 0000", vote_grant); end
    vecs++; if (spoiled_cnt !== 16'd1 || ballot_cnt !== 16'd1) begin
      errs++; $display("FAIL spoil_counts: spoiled %0d ballot %0d want 1/1", spoiled_cnt, ballot_cnt); end
    wait_cast(n, extra);
    vecs++; if (n !== 10 || phase !== 3'd1) begin
      errs++; $display("FAIL spoil_cast: len %0d phase %0d want 10/1", n, phase); end
  endtask

  task automatic test_timeout();
    int n;
    arm();
    n = 0;
    while (phase === 3'd2 && n < 2000) begin n++; tick(); end
    vecs++; if (n !== 1000) begin errs++; $display("FAIL armed_len: got %0d want 1000", n); end
    vecs++; if (phase !== 3'd1 || timeout_cnt !== 16'd1) begin
      errs++; $display("FAIL timeout: phase %0d timeout_cnt %0d want 1/1", phase, timeout_cnt); end
    vote(4'b0001);
    vecs++; if (vote_grant !== 4'b0000 || phase !== 3'd1) begin
      errs++; $display("FAIL late_vote: grant %b phase %0d want 0000/1", vote_grant, phase); end
  endtask

  task automatic test_lockout();
    int n, extra;
    vote(4'b1000);
    tick();
    vecs++; if (vote_grant !== 4'b0000 || ballot_cnt !== 16'd1 || spoiled_cnt !== 16'd1) begin
      errs++; $display("FAIL open_vote: grant %b ballot %0d spoiled %0d want 0000/1/1",
                       vote_grant, ballot_cnt, spoiled_cnt); end
    arm();
    vote(4'b0010);
    vecs++; if (vote_grant !== 4'b0010 || ballot_cnt !== 16'd2) begin
      errs++; $display("FAIL second_grant: grant %b ballot %0d want 0010/2", vote_grant, ballot_cnt); end
    tick();
    officer_enable = 1'b1; vote_req = 4'b0001; tick(); officer_enable = 1'b0; vote_req = '0;
    vecs++; if (vote_grant !== 4'b0000 || phase !== 3'd3) begin
      errs++; $display("FAIL lockout: grant %b phase %0d want 0000/3", vote_grant, phase); end
    wait_cast(n, extra);
    vecs++; if (phase !== 3'd1 || ballot_cnt !== 16'd2 || spoiled_cnt !== 16'd1 || extra !== 0) begin
      errs++; $display("FAIL lockout_after: phase %0d ballot %0d spoiled %0d extra %0d want 1/2/1/0",
                       phase, ballot_cnt, spoiled_cnt, extra); end
  endtask

  task automatic test_close_results();
    int n, extra;
    arm();
    vote(4'b0001);
    tick();
    close_poll = 1'b1; tick(); close_poll = 1'b0;
    vecs++; if (phase !== 3'd3) begin errs++; $display("FAIL close_in_cast: phase %0d want 3", phase); end
    wait_cast(n, extra);
    vecs++; if (phase !== 3'd4 || logger_en !== 1'b0) begin
      errs++; $display("FAIL closed: phase %0d logger_en %b want 4/0", phase, logger_en); end
    open_poll = 1'b1; tick(); open_poll = 1'b0;
    vecs++; if (phase !== 3'd4) begin errs++; $display("FAIL reopen: phase %0d want 4", phase); end
    arm();
    vecs++; if (phase !== 3'd5 || disp_valid !== 1'b1 || disp_sel !== 2'd0) begin
      errs++; $display("FAIL results: phase %0d disp_valid %b disp_sel %0d want 5/1/0",
                       phase, disp_valid, disp_sel); end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (disp_sel === 2'(k) && n < 200) begin n++; tick(); end
      vecs++; if (n !== 50) begin errs++; $display("FAIL scan_step%0d: got %0d cycles want 50", k, n); end
    end
    vecs++; if (disp_sel !== 2'd0 || phase !== 3'd5) begin
      errs++; $display("FAIL scan_wrap: disp_sel %0d phase %0d want 0/5", disp_sel, phase); end
  endtask

  task automatic test_reset_mid();
    int n, extra;
    reset = 1'b1; tick(); reset = 1'b0;
    open_poll = 1'b1; close_poll = 1'b1; tick(); open_poll = 1'b0; close_poll = 1'b0;
    vecs++; if (phase !== 3'd1) begin errs++; $display("FAIL open_close_same: phase %0d want 1", phase); end
    arm(); vote(4'b0100); wait_cast(n, extra);
    arm(); vote(4'b1100); wait_cast(n, extra);
    arm();
    vecs++; if (phase !== 3'd2 || ballot_cnt !== 16'd1 || spoiled_cnt !== 16'd1) begin
      errs++; $display("FAIL pre_reset: phase %0d ballot %0d spoiled %0d want 2/1/1",
                       phase, ballot_cnt, spoiled_cnt); end
    reset = 1'b1; tick(); reset = 1'b0;
    vecs++; if (phase !== 3'd0 || armed_led !== 1'b0) begin
      errs++; $display("FAIL mid_reset_phase: phase %0d armed_led %b want 0/0", phase, armed_led); end
    vecs++; if ({ballot_cnt, spoiled_cnt, timeout_cnt} !== 48'd0) begin
      errs++; $display("FAIL mid_reset_counts: got %h want 0", {ballot_cnt, spoiled_cnt, timeout_cnt}); end
  endtask

  task automatic test_saturate();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    s_open_poll = 1'b1; tick(); s_open_poll = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_officer_enable = 1'b1; tick(); s_officer_enable = 1'b0;
      s_vote_req = 4'b0001; tick(); s_vote_req = '0;
      if (i == 0) begin
        vecs++; if (s_vote_grant !== 4'b0001 || s_cast_led !== 1'b1) begin
          errs++; $display("FAIL sat_first_grant: grant %b cast %b want 0001/1", s_vote_grant, s_cast_led); end
      end
      n = 0;
      while (s_phase === 3'd3 && n < 20) begin n++; tick(); end
      if (i == 0) begin
        vecs++; if (n !== 2) begin errs++; $display("FAIL sat_hold_len: got %0d want 2", n); end
      end
      if (i == 14) begin
        vecs++; if (s_ballot_cnt !== 4'hF) begin errs++; $display("FAIL sat_reach: got %h want F", s_ballot_cnt); end
      end
    end
    vecs++; if (s_ballot_cnt !== 4'hF || s_phase !== 3'd1) begin
      errs++; $display("FAIL sat_hold: ballot %h phase %0d want F/1", s_ballot_cnt, s_phase); end
  endtask

  initial begin
    test_reset();
    test_vote();
    test_spoiled();
    test_timeout();
    test_lockout();
    test_close_results();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
